// File: rtl/security_system_zoned.sv
// security_system_zoned: multi-zone intruder alarm with debounced inputs and exit/entry delays.
// Latency: a stable zone change moves the state register DEBOUNCE_CYCLES+3 clocks later, arm +4.
// No backpressure; outputs are registered and lag the state register by one clock.

// security_system_zoned_debounce: one-bit 2-flop synchroniser followed by a hold-time filter.
// Latency: the filtered level follows a stable raw change DEBOUNCE_CYCLES+2 clocks later.
// No backpressure; pulses shorter than DEBOUNCE_CYCLES never reach the output.
module security_system_zoned_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Raw,
  output logic o_Filt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          filt_q;
  logic          filt_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count while the synchronised level disagrees with the filtered one; flip on the final count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchroniser chain and filter state.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= i_Raw;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Filt = filt_q;

endmodule

// security_system_zoned: arming FSM, tripped-zone map and LED drivers over debounced inputs.
// Latency: state register reacts DEBOUNCE_CYCLES+3 (zone) / +4 (arm) after a raw change.
// No backpressure; every output is a flop fed from the current state register.
module security_system_zoned #(
  parameter int                   NUM_ZONES          = 4,
  parameter logic [NUM_ZONES-1:0] ENTRY_ZONE_MASK    = 4'b0001,
  parameter int                   DEBOUNCE_CYCLES    = 250000,
  parameter int                   EXIT_DELAY_CYCLES  = 2500000,
  parameter int                   ENTRY_DELAY_CYCLES = 2500000,
  parameter int                   BLINK_HALF_CYCLES  = 1250000
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  input  logic [NUM_ZONES-1:0] i_Zone,
  input  logic [NUM_ZONES-1:0] i_Zone_Enable,
  input  logic                 i_Arm,
  output logic                 o_LED_Armed,
  output logic                 o_LED_Alarm,
  output logic [NUM_ZONES-1:0] o_Zone_Status,
  output logic [NUM_ZONES-1:0] o_Tripped_Zones,
  output logic [2:0]           o_State
);

  localparam int DMAX = (EXIT_DELAY_CYCLES > ENTRY_DELAY_CYCLES) ? EXIT_DELAY_CYCLES
                                                                 : ENTRY_DELAY_CYCLES;
  localparam int DW   = $clog2(DMAX + 1);
  localparam int BW   = $clog2(BLINK_HALF_CYCLES + 1);

  localparam logic [DW-1:0] EXIT_LOAD  = DW'(EXIT_DELAY_CYCLES - 1);
  localparam logic [DW-1:0] ENTRY_LOAD = DW'(ENTRY_DELAY_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_EXIT     = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } state_t;

  // Filtered inputs
  logic [NUM_ZONES-1:0] zone_f;
  logic                 arm_f;

  // Arm edge detector
  logic arm_prev_q;
  logic arm_prev_d;
  logic arm_pulse_q;
  logic arm_pulse_d;

  // Zone classification
  logic zone_inst;
  logic zone_dly;

  // FSM state and timers
  state_t               state_q;
  state_t               state_d;
  logic [DW-1:0]        dly_cnt_q;
  logic [DW-1:0]        dly_cnt_d;
  logic [BW-1:0]        blink_cnt_q;
  logic [BW-1:0]        blink_cnt_d;
  logic                 blink_q;
  logic                 blink_d;
  logic [NUM_ZONES-1:0] tripped_q;
  logic [NUM_ZONES-1:0] tripped_d;

  // Registered outputs
  logic [2:0]           state_out_q;
  logic [2:0]           state_out_d;
  logic                 led_armed_q;
  logic                 led_armed_d;
  logic                 led_alarm_q;
  logic                 led_alarm_d;

  for (genvar g = 0; g < NUM_ZONES; g++) begin : g_zone
    security_system_zoned_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_zone_db (
      .i_Clk  (i_Clk),
      .i_Reset(i_Reset),
      .i_Raw  (i_Zone[g]),
      .o_Filt (zone_f[g])
    );
  end

  security_system_zoned_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_arm_db (
    .i_Clk  (i_Clk),
    .i_Reset(i_Reset),
    .i_Raw  (i_Arm),
    .o_Filt (arm_f)
  );

  // Bypassed zones drop out here; the mask acts without any filtering.
  assign zone_inst = |(zone_f & i_Zone_Enable & ~ENTRY_ZONE_MASK);
  assign zone_dly  = |(zone_f & i_Zone_Enable & ENTRY_ZONE_MASK);

  // One-cycle pulse on each filtered press; releases are ignored.
  always_comb begin
    arm_prev_d  = arm_f;
    arm_pulse_d = arm_f & ~arm_prev_q;
  end

  // Arm edge-detector flops.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      arm_prev_q  <= 1'b0;
      arm_pulse_q <= 1'b0;
    end else begin
      arm_prev_q  <= arm_prev_d;
      arm_pulse_q <= arm_pulse_d;
    end
  end

  // Next state, delay/blink timers, tripped map and output values; arm press always wins.
  always_comb begin
    state_d     = state_q;
    dly_cnt_d   = dly_cnt_q;
    tripped_d   = tripped_q;
    blink_d     = blink_q;
    blink_cnt_d = blink_cnt_q;

    // Any enabled zone seen open while armed is remembered until the next arming.
    if (state_q == ST_ARMED || state_q == ST_ENTRY || state_q == ST_ALARM) begin
      tripped_d = tripped_q | (zone_f & i_Zone_Enable);
    end

    case (state_q)
      ST_DISARMED: begin
        if (arm_pulse_q) begin
          state_d   = ST_EXIT;
          dly_cnt_d = EXIT_LOAD;
          tripped_d = '0;
        end
      end
      ST_EXIT: begin
        if (arm_pulse_q) begin
          state_d = ST_DISARMED;
        end else if (dly_cnt_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          dly_cnt_d = dly_cnt_q - DW'(1);
        end
      end
      ST_ARMED: begin
        if (arm_pulse_q) begin
          state_d = ST_DISARMED;
        end else if (zone_inst) begin
          state_d = ST_ALARM;
        end else if (zone_dly) begin
          state_d   = ST_ENTRY;
          dly_cnt_d = ENTRY_LOAD;
        end
      end
      ST_ENTRY: begin
        // A delayed zone closing again does not cancel the countdown.
        if (arm_pulse_q) begin
          state_d = ST_DISARMED;
        end else if (zone_inst || dly_cnt_q == '0) begin
          state_d = ST_ALARM;
        end else begin
          dly_cnt_d = dly_cnt_q - DW'(1);
        end
      end
      ST_ALARM: begin
        if (arm_pulse_q) begin
          state_d = ST_DISARMED;
        end
      end
      default: begin
        state_d = ST_DISARMED;
      end
    endcase

    // Blink restarts lit on entry to a delay state, then toggles every half period.
    if ((state_d == ST_EXIT || state_d == ST_ENTRY) && state_d != state_q) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (state_q == ST_EXIT || state_q == ST_ENTRY) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end

    state_out_d = state_q;
    led_alarm_d = (state_q == ST_ALARM);
    case (state_q)
      ST_DISARMED:       led_armed_d = 1'b0;
      ST_EXIT, ST_ENTRY: led_armed_d = blink_q;
      default:           led_armed_d = 1'b1;
    endcase
  end

  // FSM and output registers.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q     <= ST_DISARMED;
      dly_cnt_q   <= '0;
      tripped_q   <= '0;
      blink_q     <= 1'b0;
      blink_cnt_q <= '0;
      state_out_q <= 3'd0;
      led_armed_q <= 1'b0;
      led_alarm_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dly_cnt_q   <= dly_cnt_d;
      tripped_q   <= tripped_d;
      blink_q     <= blink_d;
      blink_cnt_q <= blink_cnt_d;
      state_out_q <= state_out_d;
      led_armed_q <= led_armed_d;
      led_alarm_q <= led_alarm_d;
    end
  end

  assign o_State         = state_out_q;
  assign o_LED_Armed     = led_armed_q;
  assign o_LED_Alarm     = led_alarm_q;
  assign o_Zone_Status   = zone_f;
  assign o_Tripped_Zones = tripped_q;

endmodule

// File: tb/tb_security_system_zoned.sv
// tb_security_system_zoned: vector table, hand-written corner sequences, then random run vs model.
// Inputs are driven on the falling edge and outputs are sampled on the falling edge.
// Short timing parameters keep every delay to a handful of clocks.
module tb_security_system_zoned;

  localparam int NZ  = 4;
  localparam int DEB = 4;
  localparam int EXD = 8;
  localparam int ENT = 6;
  localparam int BLK = 2;
  localparam logic [NZ-1:0] MASK = 4'b0001;

  logic          i_Clk = 1'b0;
  logic          i_Reset = 1'b1;
  logic [NZ-1:0] zone = '0;
  logic [NZ-1:0] en = 4'hF;
  logic          arm = 1'b0;
  logic          o_LED_Armed;
  logic          o_LED_Alarm;
  logic [NZ-1:0] o_Zone_Status;
  logic [NZ-1:0] o_Tripped_Zones;
  logic [2:0]    o_State;

  security_system_zoned #(
    .NUM_ZONES         (NZ),
    .ENTRY_ZONE_MASK   (MASK),
    .DEBOUNCE_CYCLES   (DEB),
    .EXIT_DELAY_CYCLES (EXD),
    .ENTRY_DELAY_CYCLES(ENT),
    .BLINK_HALF_CYCLES (BLK)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Reset        (i_Reset),
    .i_Zone         (zone),
    .i_Zone_Enable  (en),
    .i_Arm          (arm),
    .o_LED_Armed    (o_LED_Armed),
    .o_LED_Alarm    (o_LED_Alarm),
    .o_Zone_Status  (o_Zone_Status),
    .o_Tripped_Zones(o_Tripped_Zones),
    .o_State        (o_State)
  );

  always #5 i_Clk = ~i_Clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge i_Clk);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          arm;
    logic [NZ-1:0] zone;
    logic [NZ-1:0] en;
    int            hold;
    logic [2:0]    st;
    logic [NZ-1:0] trip;
    logic          led;
    logic          alm;
  } vec_t;

  vec_t vecs[20];

  // ---------------- behavioural reference model ----------------
  // Synced level is the raw level two clocks late; a filtered level follows once the synced
  // level has disagreed for DEB consecutive clocks. Delays are tracked as absolute deadlines.
  logic [NZ:0]   m_s1, m_s2, m_filt;
  int            m_run[NZ+1];
  logic          m_prev, m_pulse;
  int            m_state, m_entry, m_deadline, cyc_n;
  logic [NZ-1:0] m_trip;
  logic [2:0]    x_state;
  logic          x_led, x_alarm;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_filt = '0;
    for (int b = 0; b <= NZ; b++) m_run[b] = 0;
    m_prev = 1'b0; m_pulse = 1'b0;
    m_state = 0; m_entry = 0; m_deadline = 0; cyc_n = 0;
    m_trip = '0;
    x_state = 3'd0; x_led = 1'b0; x_alarm = 1'b0;
  endtask

  task automatic model_step();
    logic [NZ-1:0] zf;
    logic inst, dly;
    zf = m_filt[NZ-1:0];
    cyc_n++;
    // outputs show the state held during the clock that just ended
    x_state = 3'(m_state);
    x_alarm = (m_state == 4);
    if (m_state == 1 || m_state == 3) x_led = (((cyc_n - 1 - m_entry) / BLK) % 2) == 0;
    else                              x_led = (m_state != 0);
    inst = |(zf & en & ~MASK);
    dly  = |(zf & en & MASK);
    if (m_state >= 2) m_trip = m_trip | (zf & en);
    if (m_pulse) begin
      if (m_state == 0) begin
        m_state = 1; m_entry = cyc_n; m_deadline = cyc_n + EXD; m_trip = '0;
      end else begin
        m_state = 0;
      end
    end else begin
      case (m_state)
        1: if (cyc_n == m_deadline) m_state = 2;
        2: if (inst) m_state = 4;
           else if (dly) begin m_state = 3; m_entry = cyc_n; m_deadline = cyc_n + ENT; end
        3: if (inst || cyc_n == m_deadline) m_state = 4;
        default: ;
      endcase
    end
    m_pulse = m_filt[NZ] & ~m_prev;
    m_prev  = m_filt[NZ];
    for (int b = 0; b <= NZ; b++) begin
      if (m_s2[b] != m_filt[b]) begin
        m_run[b]++;
        if (m_run[b] == DEB) begin m_filt[b] = m_s2[b]; m_run[b] = 0; end
      end else begin
        m_run[b] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = {arm, zone};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] pat;

    //            arm   zone     en      hold st    trip     led   alm
    vecs[0]  = '{1'b0, 4'b0000, 4'b1111, 3,  3'd0, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'b0000, 4'b1111, 3,  3'd0, 4'b0000, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 4'b1111, 10, 3'd0, 4'b0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'b0000, 4'b1111, 6,  3'd0, 4'b0000, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 4'b0000, 4'b1111, 20, 3'd2, 4'b0000, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'b0001, 4'b1111, 9,  3'd3, 4'b0001, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 4'b1111, 10, 3'd4, 4'b0001, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 4'b0000, 4'b1111, 6,  3'd4, 4'b0001, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 4'b0000, 4'b1111, 10, 3'd0, 4'b0001, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 4'b0000, 4'b1111, 6,  3'd0, 4'b0001, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 4'b1111, 20, 3'd2, 4'b0000, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'b0100, 4'b1111, 10, 3'd4, 4'b0100, 1'b1, 1'b1};
    vecs[12] = '{1'b1, 4'b0000, 4'b1111, 6,  3'd4, 4'b0100, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 4'b0000, 4'b1111, 10, 3'd0, 4'b0100, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 4'b0000, 4'b1111, 6,  3'd0, 4'b0100, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 4'b0000, 4'b1111, 20, 3'd2, 4'b0000, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 4'b0100, 4'b1011, 12, 3'd2, 4'b0000, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 4'b0100, 4'b1111, 10, 3'd4, 4'b0100, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 4'b0000, 4'b1111, 6,  3'd4, 4'b0100, 1'b1, 1'b1};
    vecs[19] = '{1'b0, 4'b0000, 4'b1111, 10, 3'd0, 4'b0100, 1'b0, 1'b0};

    // reset state
    cyc(2);
    check("reset_state", o_State, 3'd0);
    check("reset_outputs", {o_LED_Armed, o_LED_Alarm, o_Zone_Status, o_Tripped_Zones}, '0);
    i_Reset = 1'b0;

    // table-driven scenario: glitch, arming, entry path, instant zone, bypass
    for (int i = 0; i < 20; i++) begin
      arm  = vecs[i].arm;
      zone = vecs[i].zone;
      en   = vecs[i].en;
      cyc(vecs[i].hold);
      check($sformatf("vec%0d_state", i), o_State, vecs[i].st);
      check($sformatf("vec%0d_trip", i), o_Tripped_Zones, vecs[i].trip);
      check($sformatf("vec%0d_led_armed", i), o_LED_Armed, vecs[i].led);
      check($sformatf("vec%0d_led_alarm", i), o_LED_Alarm, vecs[i].alm);
    end

    // zone 2 opens and closes entirely inside the exit delay: nothing latched, ARMED reached
    arm = 1'b1; cyc(2);
    zone = 4'b0100; cyc(3);
    arm = 1'b0; cyc(2);
    zone = 4'b0000; cyc(2);
    for (int j = 0; j < 11; j++) begin
      check("exit_zone_trip", o_Tripped_Zones, 4'b0000);
      cyc(1);
    end
    check("exit_zone_state", o_State, 3'd2);
    check("exit_zone_alarm", o_LED_Alarm, 1'b0);

    // arm press lands in the same cycle as an instant zone while ARMED: disarm wins
    arm = 1'b1; cyc(1);
    zone = 4'b0100; cyc(4);
    arm = 1'b0; cyc(7);
    check("prio_state", o_State, 3'd0);
    check("prio_alarm", o_LED_Alarm, 1'b0);
    check("prio_trip", o_Tripped_Zones, 4'b0100);
    zone = 4'b0000; cyc(8);

    // exit-delay latency and blink pattern
    pat = 8'b0011_0011;
    arm = 1'b1; cyc(5);
    arm = 1'b0;
    k = 5;
    while (o_State != 3'd1 && k < 30) begin
      cyc(1);
      k++;
    end
    check("exit_latency", k, 9);
    for (int j = 0; j < 8; j++) begin
      check($sformatf("exit_state_%0d", j), o_State, 3'd1);
      check($sformatf("exit_blink_%0d", j), o_LED_Armed, pat[j]);
      cyc(1);
    end
    check("armed_state", o_State, 3'd2);
    check("armed_led", o_LED_Armed, 1'b1);
    check("armed_trip_cleared", o_Tripped_Zones, 4'b0000);

    // asynchronous reset in the middle of an alarm
    zone = 4'b0100; cyc(10);
    check("pre_reset_state", o_State, 3'd4);
    #2;
    i_Reset = 1'b1;
    #1;
    check("async_reset_state", o_State, 3'd0);
    check("async_reset_outputs", {o_LED_Armed, o_LED_Alarm, o_Zone_Status, o_Tripped_Zones}, '0);
    cyc(2);
    i_Reset = 1'b0;
    zone = 4'b0000;
    cyc(2);
    check("post_reset_state", o_State, 3'd0);
    check("post_reset_alarm", o_LED_Alarm, 1'b0);

    // randomized run against the reference model
    i_Reset = 1'b1; arm = 1'b0; zone = '0; en = 4'hF;
    model_reset();
    cyc(1);
    i_Reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      check("rand_state", o_State, x_state);
      check("rand_led_armed", o_LED_Armed, x_led);
      check("rand_led_alarm", o_LED_Alarm, x_alarm);
      check("rand_zone_status", o_Zone_Status, m_filt[NZ-1:0]);
      check("rand_tripped", o_Tripped_Zones, m_trip);
      if ($urandom_range(5) == 0) arm = ~arm;
      for (int b = 0; b < NZ; b++) begin
        if ($urandom_range(9) == 0) zone[b] = ~zone[b];
      end
      if ($urandom_range(49) == 0) en = $urandom_range(1) ? 4'hF : 4'($urandom_range(15));
      @(posedge i_Clk);
      model_step();
      @(negedge i_Clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
